sha256_build_arbiter: RTL and testbench

Round-robin packet arbiter that shares one `sha256_message_build` instance between two independent requesters. Each requester presents a config stream and a 512-bit data stream. The arbiter grants one requester a whole packet: its config transfer, then every data beat up to and including `data_in_last`. It records the granted requester ID in a small FIFO so downstream digest logic can route results back in order.

---
 rtl/sha256_build_arbiter.sv | 146 ++++++++++++++
 tb/tb_sha256_build_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_build_arbiter.sv
// Round-robin packet arbiter sharing one message builder between two requesters.
// A grant covers one config transfer plus all data beats; grant IDs are queued for routing.
module sha256_build_arbiter #(
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,

  input  logic [511:0] r0_data,
  input  logic         r0_data_last,
  input  logic         r0_data_valid,
  output logic         r0_data_ready,
  input  logic [63:0]  r0_cfg_size,
  input  logic [1:0]   r0_cfg_scheme,
  input  logic         r0_cfg_last,
  input  logic         r0_cfg_valid,
  output logic         r0_cfg_ready,

  input  logic [511:0] r1_data,
  input  logic         r1_data_last,
  input  logic         r1_data_valid,
  output logic         r1_data_ready,
  input  logic [63:0]  r1_cfg_size,
  input  logic [1:0]   r1_cfg_scheme,
  input  logic         r1_cfg_last,
  input  logic         r1_cfg_valid,
  output logic         r1_cfg_ready,

  output logic [511:0] mb_data,
  output logic         mb_data_last,
  output logic         mb_data_valid,
  input  logic         mb_data_ready,
  output logic [63:0]  mb_cfg_size,
  output logic [1:0]   mb_cfg_scheme,
  output logic         mb_cfg_last,
  output logic         mb_cfg_valid,
  input  logic         mb_cfg_ready,

  output logic         id_out,
  output logic         id_out_valid,
  input  logic         id_out_ready,
  output logic         busy
);

  localparam int unsigned PtrW = $clog2(ID_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StCfg, StData} state_e;

  state_e                   state_q;
  logic                     grant_q;
  logic                     prio_q;
  logic [ID_FIFO_DEPTH-1:0] fifo_q;
  logic [PtrW-1:0]          wr_ptr_q;
  logic [PtrW-1:0]          rd_ptr_q;
  logic [CntW-1:0]          count_q;

  logic in_cfg, in_data;
  logic not_full, winner;
  logic cfg_hs, data_hs, push, pop;

  assign in_cfg   = en && (state_q == StCfg);
  assign in_data  = en && (state_q == StData);
  assign not_full = count_q < CntW'(ID_FIFO_DEPTH);
  // On a tie the priority holder wins; otherwise whichever requester is asking.
  assign winner   = (r0_cfg_valid && r1_cfg_valid) ? prio_q : r1_cfg_valid;

  always_comb begin
    mb_cfg_size   = '0;
    mb_cfg_scheme = '0;
    mb_cfg_last   = 1'b0;
    mb_data       = '0;
    mb_data_last  = 1'b0;
    if (state_q == StCfg) begin
      mb_cfg_size   = grant_q ? r1_cfg_size   : r0_cfg_size;
      mb_cfg_scheme = grant_q ? r1_cfg_scheme : r0_cfg_scheme;
      mb_cfg_last   = grant_q ? r1_cfg_last   : r0_cfg_last;
    end
    if (state_q == StData) begin
      mb_data      = grant_q ? r1_data      : r0_data;
      mb_data_last = grant_q ? r1_data_last : r0_data_last;
    end
  end

  assign mb_cfg_valid  = in_cfg  && (grant_q ? r1_cfg_valid  : r0_cfg_valid);
  assign mb_data_valid = in_data && (grant_q ? r1_data_valid : r0_data_valid);
  assign r0_cfg_ready  = in_cfg  && !grant_q && mb_cfg_ready;
  assign r1_cfg_ready  = in_cfg  &&  grant_q && mb_cfg_ready;
  assign r0_data_ready = in_data && !grant_q && mb_data_ready;
  assign r1_data_ready = in_data &&  grant_q && mb_data_ready;

  assign cfg_hs  = mb_cfg_valid && mb_cfg_ready;
  assign data_hs = mb_data_valid && mb_data_ready;
  assign push    = cfg_hs && mb_cfg_last;

  assign id_out_valid = en && (count_q != '0);
  assign id_out       = fifo_q[rd_ptr_q];
  assign pop          = id_out_valid && id_out_ready;
  assign busy         = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!nrst || sync_rst) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      prio_q   <= 1'b0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en) begin
      case (state_q)
        StIdle: begin
          if ((r0_cfg_valid || r1_cfg_valid) && not_full) begin
            grant_q <= winner;
            state_q <= StCfg;
          end
        end
        StCfg: begin
          if (push) state_q <= StData;
        end
        StData: begin
          if (data_hs && mb_data_last) begin
            state_q <= StIdle;
            prio_q  <= ~grant_q;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Grant already required not-full, so a push never overflows.
      if (push) begin
        fifo_q[wr_ptr_q] <= grant_q;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sha256_build_arbiter.sv
// Directed bench for sha256_build_arbiter: requester drivers plus expected grant order per test.
module tb_sha256_build_arbiter;

  logic         clk = 1'b0;
  logic         nrst, en, sync_rst;
  logic [511:0] rd [2];
  logic         rl [2], rv [2], rr [2];
  logic [63:0]  cs [2];
  logic [1:0]   csc [2];
  logic         cl [2], cv [2], cr [2];
  logic [511:0] mb_data;
  logic         mb_data_last, mb_data_valid, mb_data_ready;
  logic [63:0]  mb_cfg_size;
  logic [1:0]   mb_cfg_scheme;
  logic         mb_cfg_last, mb_cfg_valid, mb_cfg_ready;
  logic         id_out, id_out_valid, id_out_ready, busy;

  always #5 clk = ~clk;

  sha256_build_arbiter #(.ID_FIFO_DEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
    .r0_data(rd[0]), .r0_data_last(rl[0]), .r0_data_valid(rv[0]), .r0_data_ready(rr[0]),
    .r0_cfg_size(cs[0]), .r0_cfg_scheme(csc[0]), .r0_cfg_last(cl[0]),
    .r0_cfg_valid(cv[0]), .r0_cfg_ready(cr[0]),
    .r1_data(rd[1]), .r1_data_last(rl[1]), .r1_data_valid(rv[1]), .r1_data_ready(rr[1]),
    .r1_cfg_size(cs[1]), .r1_cfg_scheme(csc[1]), .r1_cfg_last(cl[1]),
    .r1_cfg_valid(cv[1]), .r1_cfg_ready(cr[1]),
    .mb_data(mb_data), .mb_data_last(mb_data_last), .mb_data_valid(mb_data_valid),
    .mb_data_ready(mb_data_ready),
    .mb_cfg_size(mb_cfg_size), .mb_cfg_scheme(mb_cfg_scheme), .mb_cfg_last(mb_cfg_last),
    .mb_cfg_valid(mb_cfg_valid), .mb_cfg_ready(mb_cfg_ready),
    .id_out(id_out), .id_out_valid(id_out_valid), .id_out_ready(id_out_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester driver state and per-test expectations
  int pk [2];
  int beat [2];
  bit ph [2];
  int nbeats, cyc, n_cfg, n_dat, n_pop;
  bit bp_mode, id_rdy, en_drv, idle_next;
  int exp_g [$];

  function automatic logic [511:0] pat(int i, int p, int b);
    return {16{8'(i), 8'(p), 8'(b), 8'h5a}};
  endfunction

  function automatic logic [63:0] sz(int i, int p);
    return 64'(24 + 1000 * i + 8 * (p - 1));
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      cv[i]  = !ph[i] && (pk[i] > 0);
      cs[i]  = sz(i, pk[i]);
      csc[i] = 2'(2 * i);
      cl[i]  = 1'b1;
      rv[i]  = ph[i];
      rd[i]  = ph[i] ? pat(i, pk[i], beat[i]) : '0;
      rl[i]  = ph[i] && (beat[i] == nbeats - 1);
    end
    mb_cfg_ready  = 1'b1;
    mb_data_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    id_out_ready  = id_rdy;
    en            = en_drv;
    cyc++;
  endtask

  task automatic observe();
    int g;
    check("exclusive_ready", 512'((cr[0] | rr[0]) & (cr[1] | rr[1])), 512'(0));
    if (mb_data_valid) check("data_ready_mirror", 512'(rr[0] | rr[1]), 512'(mb_data_ready));
    if (idle_next) begin
      check("gap_busy", 512'(busy), 512'(0));
      check("gap_cfg_valid", 512'(mb_cfg_valid), 512'(0));
      idle_next = 1'b0;
    end
    if (mb_cfg_valid && mb_cfg_ready) begin
      if (n_cfg >= exp_g.size()) begin
        check("grant_count", 512'(n_cfg + 1), 512'(exp_g.size()));
      end else begin
        g = exp_g[n_cfg];
        check("grant", 512'(cr[1]), 512'(g));
        check("cfg_size", 512'(mb_cfg_size), 512'(sz(g, pk[g])));
        check("cfg_scheme", 512'(mb_cfg_scheme), 512'(2 * g));
      end
      n_cfg++;
    end
    if (mb_data_valid && mb_data_ready && n_cfg > 0 && n_cfg <= exp_g.size()) begin
      g = exp_g[n_cfg - 1];
      check("data", mb_data, pat(g, pk[g], beat[g]));
      check("data_last", 512'(mb_data_last), 512'(beat[g] == nbeats - 1));
      n_dat++;
      if (mb_data_last) idle_next = 1'b1;
    end
    if (id_out_valid && id_out_ready) begin
      if (n_pop < exp_g.size()) check("fifo_id", 512'(id_out), 512'(exp_g[n_pop]));
      n_pop++;
    end
    for (int i = 0; i < 2; i++) begin
      if (cv[i] && cr[i]) begin
        ph[i]   = 1'b1;
        beat[i] = 0;
      end else if (rv[i] && rr[i]) begin
        beat[i]++;
        if (beat[i] == nbeats) begin
          ph[i]   = 1'b0;
          beat[i] = 0;
          pk[i]--;
        end
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      drive();
      #1;
      observe();
    end
  endtask

  task automatic clear_counts();
    n_cfg = 0; n_dat = 0; n_pop = 0; idle_next = 1'b0;
    exp_g.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    pk = '{0, 0}; beat = '{0, 0}; ph = '{0, 0};
    nbeats = 1; bp_mode = 1'b0; id_rdy = 1'b1; en_drv = 1'b1; cyc = 0;
    clear_counts();
    drive();
    @(negedge clk);
    nrst = 1'b1;
    #1;
  endtask

  initial begin
    nrst = 1'b0; sync_rst = 1'b0; en = 1'b1;
    do_reset();

    // Reset state
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_readies", 512'({cr[0], cr[1], rr[0], rr[1]}), 512'(0));
    check("rst_mb_valids", 512'({mb_cfg_valid, mb_data_valid}), 512'(0));
    check("rst_id_valid", 512'(id_out_valid), 512'(0));
    check("rst_id", 512'(id_out), 512'(0));
    check("rst_mb_data", mb_data, 512'(0));
    check("rst_mb_size", 512'(mb_cfg_size), 512'(0));

    // Single requester: r0 cfg size 24, one data beat
    do_reset();
    pk = '{1, 0}; nbeats = 1; exp_g = '{0};
    run(8);
    check("t1_cfg", 512'(n_cfg), 512'(1));
    check("t1_dat", 512'(n_dat), 512'(1));
    check("t1_pop", 512'(n_pop), 512'(1));

    // Contention: three 2-beat packets each, strict alternation from r0
    do_reset();
    pk = '{3, 3}; nbeats = 2; exp_g = '{0, 1, 0, 1, 0, 1};
    run(40);
    check("t2_cfg", 512'(n_cfg), 512'(6));
    check("t2_dat", 512'(n_dat), 512'(12));
    check("t2_pop", 512'(n_pop), 512'(6));

    // Backpressure: 4-beat r1 packet, builder ready one cycle in three
    do_reset();
    pk = '{0, 1}; nbeats = 4; bp_mode = 1'b1; exp_g = '{1};
    run(30);
    check("t3_cfg", 512'(n_cfg), 512'(1));
    check("t3_dat", 512'(n_dat), 512'(4));

    // FIFO full: five packets queued with no ID reads
    do_reset();
    pk = '{3, 2}; nbeats = 1; id_rdy = 1'b0; exp_g = '{0, 1, 0, 1, 0};
    run(30);
    check("t4_granted", 512'(n_cfg), 512'(4));
    check("t4_busy", 512'(busy), 512'(0));
    check("t4_waiting", 512'({cv[0], cr[0]}), 512'(2'b10));
    id_rdy = 1'b1;
    run(1);
    check("t4_pop1", 512'(n_pop), 512'(1));
    id_rdy = 1'b0;
    run(1);
    check("t4_still_idle", 512'(busy), 512'(0));
    check("t4_no_grant_yet", 512'(n_cfg), 512'(4));
    run(1);
    check("t4_fifth_grant", 512'(n_cfg), 512'(5));
    id_rdy = 1'b1;
    run(12);
    check("t4_drain", 512'(n_pop), 512'(5));

    // Mid-packet reset during r1 DATA
    do_reset();
    pk = '{0, 1}; nbeats = 4; exp_g = '{1};
    run(3);
    check("t5_in_data", 512'(rr[1]), 512'(1));
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("t5_busy", 512'(busy), 512'(0));
    check("t5_readies", 512'({cr[0], cr[1], rr[0], rr[1]}), 512'(0));
    check("t5_id_valid", 512'(id_out_valid), 512'(0));
    pk = '{1, 1}; beat = '{0, 0}; ph = '{0, 0}; nbeats = 1;
    clear_counts();
    exp_g = '{0, 1};
    run(12);
    check("t5_cfg", 512'(n_cfg), 512'(2));
    check("t5_pop", 512'(n_pop), 512'(2));

    // Enable hold for three cycles while in CFG
    do_reset();
    pk = '{1, 0}; nbeats = 1; exp_g = '{0};
    run(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en = 1'b0;
      #1;
      check("t6_busy_held", 512'(busy), 512'(1));
      check("t6_valids", 512'({mb_cfg_valid, mb_data_valid, id_out_valid}), 512'(0));
      check("t6_readies", 512'({cr[0], cr[1], rr[0], rr[1]}), 512'(0));
    end
    check("t6_no_hs", 512'(n_cfg), 512'(0));
    en_drv = 1'b1;
    run(10);
    check("t6_cfg", 512'(n_cfg), 512'(1));
    check("t6_dat", 512'(n_dat), 512'(1));
    check("t6_pop", 512'(n_pop), 512'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
